iterative_divider: RTL

Multi-cycle signed/unsigned 32-bit divide and remainder unit, attached to the execute stage beside the combinational ALU. The pipeline issues the operation over a valid/ready request handshake and receives the result over a valid/ready response handshake. This takes divide and modulo off the single-cycle ALU path. A restoring radix-2 core produces one quotient bit per cycle and applies sign correction at the end. Divide-by-zero and signed-overflow cases take a fast path.

---
 rtl/alu_pkg.sv | 10 +
 rtl/div_step.sv | 16 +
 rtl/iterative_divider.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings, states and constants for the iterative divider
package alu_pkg;
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;
    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} div_state_e;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);
    logic [WIDTH:0] sh, diff;
    assign sh     = {rem_i, msb_i};
    assign diff   = sh - {1'b0, divisor_i};
    assign qbit_o = ~diff[WIDTH];
    assign rem_o  = qbit_o ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
endmodule

// File: rtl/iterative_divider.sv
// iterative_divider: multi-cycle signed/unsigned divide and remainder unit
module iterative_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    input  logic [1:0]       Op,
    input  logic             Kill,
    output logic             RespValid,
    input  logic             RespReady,
    output logic [WIDTH-1:0] Result,
    output logic             ZeroFlag,
    output logic             OverflowFlag,
    output logic             DivZeroFlag
);
    localparam int CW = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d, res_q, res_d;
    logic             rem_sel_q, rem_sel_d, qneg_q, qneg_d, rneg_q, rneg_d;
    logic             zero_q, zero_d, ovf_q, ovf_d, dz_q, dz_d, vld_q, vld_d;
    logic [WIDTH-1:0] step_rem, abs1, abs2, special_res, fix_q, fix_r, fix_res;
    logic             step_q, sgn, s1, s2, dz_in, ovf_in;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i    (rem_q),
        .msb_i    (dvd_q[WIDTH-1]),
        .divisor_i(dvs_q),
        .rem_o    (step_rem),
        .qbit_o   (step_q)
    );

    assign sgn         = (Op == DIV_OP_DIV) || (Op == DIV_OP_REM);
    assign s1          = sgn & Operand1[WIDTH-1];
    assign s2          = sgn & Operand2[WIDTH-1];
    assign abs1        = s1 ? -Operand1 : Operand1;
    assign abs2        = s2 ? -Operand2 : Operand2;
    assign dz_in       = Operand2 == '0;
    assign ovf_in      = sgn && Operand1 == INT_MIN && (&Operand2);
    assign special_res = dz_in ? (Op[1] ? Operand1 : DIV_ZERO_QUOT) : (Op[1] ? '0 : INT_MIN);
    assign fix_q       = qneg_q ? -dvd_q : dvd_q;
    assign fix_r       = rneg_q ? -rem_q : rem_q;
    assign fix_res     = rem_sel_q ? fix_r : fix_q;

    // Next-state, datapath and flag updates; Kill overrides every transition
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        res_d     = res_q;
        rem_sel_d = rem_sel_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        dz_d      = dz_q;
        case (state_q)
            S_IDLE: if (ReqValid && !Kill) begin
                rem_sel_d = Op[1];
                ovf_d     = ovf_in;
                dz_d      = dz_in;
                if (dz_in || ovf_in) begin
                    res_d   = special_res;
                    zero_d  = special_res == '0;
                    state_d = S_DONE;
                end else begin
                    dvd_d   = abs1;
                    dvs_d   = abs2;
                    qneg_d  = s1 ^ s2;
                    rneg_d  = s1;
                    rem_d   = '0;
                    cnt_d   = '1;
                    res_d   = '0;
                    zero_d  = 1'b0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                rem_d   = step_rem;
                dvd_d   = {dvd_q[WIDTH-2:0], step_q};
                cnt_d   = cnt_q - 1'b1;
                state_d = cnt_q == '0 ? S_FIX : S_CALC;
            end
            S_FIX: begin
                res_d   = fix_res;
                zero_d  = fix_res == '0;
                state_d = S_DONE;
            end
            default: state_d = RespReady ? S_IDLE : S_DONE;
        endcase
        if (Kill) state_d = S_IDLE;
        vld_d = state_d == S_DONE;
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            res_q     <= '0;
            rem_sel_q <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            dz_q      <= 1'b0;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            res_q     <= res_d;
            rem_sel_q <= rem_sel_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            dz_q      <= dz_d;
            vld_q     <= vld_d;
        end
    end

    assign ReqReady     = state_q == S_IDLE;
    assign RespValid    = vld_q;
    assign Result       = res_q;
    assign ZeroFlag     = zero_q;
    assign OverflowFlag = ovf_q;
    assign DivZeroFlag  = dz_q;
endmodule
